// File: rtl/alu_cinate_pkg.sv
// Shared types and widths for the alu_cinate ALU.
package alu_cinate_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b11
    } shift_e;

endpackage

// File: rtl/alu_cinate_shifter.sv
// Barrel shifter for SLL / SRL / SRA; only the low SHAMT_W bits of the amount are used.
module alu_cinate_shifter
    import alu_cinate_pkg::*;
(
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_e             kind,
    output logic [DATA_W-1:0]  result
);

    always_comb begin
        result = operand << shamt;
        case (kind)
            SH_SRL:  result = operand >> shamt;
            SH_SRA:  result = $unsigned($signed(operand) >>> shamt);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cinate.sv
// 32-bit ALU with combinational result and a valid-qualified output register.
// Optional Carry/Overflow/Negative flag outputs when ALU_CINATE_FLAGS_EN is defined.
module alu_cinate
    import alu_cinate_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [3:0]        ALUControl,
    input  logic              InValid,
    output logic [DATA_W-1:0] ALUResult,
    output logic              Zero,
    output logic [DATA_W-1:0] ResultQ,
    output logic              ZeroQ,
`ifdef ALU_CINATE_FLAGS_EN
    output logic              ValidQ,
    output logic              Carry,
    output logic              Overflow,
    output logic              Negative
`else
    output logic              ValidQ
`endif
);

    alu_op_e           op;
    logic              use_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              lt_s;
    logic              lt_u;
    logic [DATA_W-1:0] sh_res;
    shift_e            sh_kind;

    assign op = alu_op_e'(ALUControl);

    // Comparisons reuse the subtractor: A + ~B + 1.
    assign use_sub = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    assign b_eff   = use_sub ? ~SrcB : SrcB;
    assign {cout, sum} = {1'b0, SrcA} + {1'b0, b_eff} + {{DATA_W{1'b0}}, use_sub};
    assign ovf  = (SrcA[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != SrcA[DATA_W-1]);
    assign lt_s = sum[DATA_W-1] ^ ovf;
    assign lt_u = ~cout;

    // Opcode bits {3,2} already encode the shift type for SLL/SRL/SRA.
    assign sh_kind = shift_e'(ALUControl[3:2]);

    alu_cinate_shifter u_shifter (
        .operand (SrcA),
        .shamt   (SrcB[SHAMT_W-1:0]),
        .kind    (sh_kind),
        .result  (sh_res)
    );

    always_comb begin
        ALUResult = '0;
        case (op)
            OP_ADD, OP_SUB:         ALUResult = sum;
            OP_SLL, OP_SRL, OP_SRA: ALUResult = sh_res;
            OP_SLT:                 ALUResult = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLTU:                ALUResult = {{(DATA_W-1){1'b0}}, lt_u};
            OP_XOR:                 ALUResult = SrcA ^ SrcB;
            OP_OR:                  ALUResult = SrcA | SrcB;
            OP_AND:                 ALUResult = SrcA & SrcB;
            default:                ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

`ifdef ALU_CINATE_FLAGS_EN
    logic arith;
    assign arith    = (op == OP_ADD) || (op == OP_SUB);
    assign Carry    = arith & cout;
    assign Overflow = arith & ovf;
    assign Negative = ALUResult[DATA_W-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ResultQ <= '0;
            ZeroQ   <= 1'b0;
            ValidQ  <= 1'b0;
        end else begin
            ValidQ <= InValid;
            if (InValid) begin
                ResultQ <= ALUResult;
                ZeroQ   <= Zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_cinate.sv
// Directed + reference-model bench for alu_cinate.
module tb_alu_cinate;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  ALUControl;
    logic        InValid;
    logic [31:0] ALUResult, ResultQ;
    logic        Zero, ZeroQ, ValidQ;
`ifdef ALU_CINATE_FLAGS_EN
    logic        Carry, Overflow, Negative;
`endif

    int nvec = 0;
    int nmiss = 0;

    always #5 clk = ~clk;

    alu_cinate dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .InValid    (InValid),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ResultQ    (ResultQ),
        .ZeroQ      (ZeroQ),
`ifdef ALU_CINATE_FLAGS_EN
        .ValidQ     (ValidQ),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .Negative   (Negative)
`else
        .ValidQ     (ValidQ)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << s;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> s;
            4'b1101: return $unsigned($signed(a) >>> s);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic comb(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
        ALUControl = op;
        SrcA = a;
        SrcB = b;
        #1;
        chk(tag, ALUResult, exp_r);
        chk({tag, "_z"}, 32'(Zero), 32'(exp_z));
    endtask

    logic [31:0] exp_q;
    logic        exp_zq;
    logic        exp_v;

    initial begin
        reset = 1'b1;
        InValid = 1'b1;
        SrcA = 32'd10;
        SrcB = 32'd20;
        ALUControl = 4'b0000;

        // reset held for two cycles; combinational path stays live meanwhile
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_resq", ResultQ, 32'd0);
        chk("rst_zq", 32'(ZeroQ), 32'd0);
        chk("rst_vq", 32'(ValidQ), 32'd0);
        chk("rst_comb", ALUResult, 32'd30);

        comb("add", 4'b0000, 32'd10, 32'd20, 32'd30, 1'b0);
        comb("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        comb("sub_eq", 4'b1000, 32'd50, 32'd50, 32'd0, 1'b1);
        comb("sub_neg", 4'b1000, 32'd10, 32'd20, 32'hFFFFFFF6, 1'b0);
        comb("and", 4'b0111, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1);
        comb("or", 4'b0110, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
        comb("xor", 4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0);
        comb("sll", 4'b0001, 32'd1, 32'd4, 32'h10, 1'b0);
        comb("srl", 4'b0101, 32'hF0000000, 32'd4, 32'h0F000000, 1'b0);
        comb("sra", 4'b1101, 32'hF0000000, 32'd4, 32'hFF000000, 1'b0);
        comb("sll_hib", 4'b0001, 32'd1, 32'h24, 32'h10, 1'b0);
        comb("sra_hib", 4'b1101, 32'hF0000000, 32'h24, 32'hFF000000, 1'b0);
        comb("sll_0", 4'b0001, 32'h12345678, 32'h20, 32'h12345678, 1'b0);
        comb("slt", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        comb("sltu", 4'b0011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        comb("slt_ovf", 4'b0010, 32'h80000000, 32'h00000001, 32'd1, 1'b0);
        comb("sltu_lt", 4'b0011, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0);
        comb("unused", 4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b1);
        comb("unused9", 4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b1);

`ifdef ALU_CINATE_FLAGS_EN
        comb("f_add_c", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        chk("carry_add", 32'(Carry), 32'd1);
        chk("ovf_add", 32'(Overflow), 32'd0);
        comb("f_add_v", 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0);
        chk("ovf_add2", 32'(Overflow), 32'd1);
        chk("neg", 32'(Negative), 32'd1);
        chk("carry_add2", 32'(Carry), 32'd0);
        comb("f_sub", 4'b1000, 32'd10, 32'd20, 32'hFFFFFFF6, 1'b0);
        chk("carry_sub", 32'(Carry), 32'd0);
        comb("f_sub2", 4'b1000, 32'd20, 32'd10, 32'd10, 1'b0);
        chk("carry_sub2", 32'(Carry), 32'd1);
        comb("f_or", 4'b0110, 32'h80000000, 32'd0, 32'h80000000, 1'b0);
        chk("carry_or", 32'(Carry), 32'd0);
`endif

        // registered path: capture, then hold
        reset = 1'b0;
        InValid = 1'b1;
        ALUControl = 4'b0000; SrcA = 32'd10; SrcB = 32'd20;
        @(posedge clk); #1;
        chk("cap_resq", ResultQ, 32'd30);
        chk("cap_vq", 32'(ValidQ), 32'd1);
        chk("cap_zq", 32'(ZeroQ), 32'd0);
        InValid = 1'b0;
        ALUControl = 4'b1000; SrcA = 32'd50; SrcB = 32'd50;
        @(posedge clk); #1;
        chk("hold_resq", ResultQ, 32'd30);
        chk("hold_zq", 32'(ZeroQ), 32'd0);
        chk("hold_vq", 32'(ValidQ), 32'd0);
        InValid = 1'b1;
        @(posedge clk); #1;
        chk("cap2_zq", 32'(ZeroQ), 32'd1);
        // reset mid-stream wins over InValid
        reset = 1'b1;
        ALUControl = 4'b0000; SrcA = 32'd1; SrcB = 32'd2;
        @(posedge clk); #1;
        chk("mid_vq", 32'(ValidQ), 32'd0);
        chk("mid_resq", ResultQ, 32'd0);
        reset = 1'b0;

        exp_q = 32'd0; exp_zq = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] r;
            ALUControl = 4'($urandom_range(0, 15));
            SrcA = $urandom;
            SrcB = ($urandom_range(0, 3) == 0) ? SrcA : $urandom;
            InValid = 1'($urandom_range(0, 1));
            #1;
            r = ref_alu(ALUControl, SrcA, SrcB);
            chk("rnd_res", ALUResult, r);
            chk("rnd_z", 32'(Zero), 32'(r == 32'd0));
            if (InValid) begin
                exp_q = r;
                exp_zq = (r == 32'd0);
            end
            exp_v = InValid;
            @(posedge clk); #1;
            chk("rnd_resq", ResultQ, exp_q);
            chk("rnd_zq", 32'(ZeroQ), 32'(exp_zq));
            chk("rnd_vq", 32'(ValidQ), 32'(exp_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/alu_cinate.md
ALU_CINATE -- requirements
Module: alu_cinate

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 SrcA  input  32  first operand (shifted value for shifts).
REQ-003 SrcB  input  32  second operand; bits [4:0] are the shift amount for shifts.
REQ-004 ALUControl  input  4  operation select.
REQ-005 InValid  input  1  high when operands and op are to be captured into the output register.
REQ-006 ALUResult  output  32  combinational result.
REQ-007 Zero  output  1  combinational, high iff ALUResult == 0.
REQ-008 ResultQ  output  32  registered ALUResult.
REQ-009 ZeroQ  output  1  registered Zero.
REQ-010 ValidQ  output  1  registered InValid, qualifies ResultQ and ZeroQ.

Function
REQ-011 ALUResult and Zero SHALL be purely combinational, settling within the same delta/cycle with no clock dependence.
REQ-012 Encoding: 0000 ADD (A+B); 1000 SUB (A-B); 0001 SLL (A<<B[4:0]); 0010 SLT (signed A<B ? 1 : 0); 0011 SLTU (unsigned A<B ? 1 : 0); 0100 XOR; 0101 SRL (logical A>>B[4:0]); 1101 SRA (arithmetic, sign-filled); 0110 OR; 0111 AND.
REQ-013 ADD and SUB SHALL wrap modulo 2^32, with carry discarded (0xFFFFFFFF+1 = 0; 10-20 = 0xFFFFFFF6).
REQ-014 Shifts SHALL use only SrcB[4:0] and ignore SrcB[31:5]; a shift by 0 returns SrcA unchanged.
REQ-015 SLT/SLTU results SHALL be zero-extended to 32 bits (value 0 or 1).
REQ-016 Every unlisted ALUControl code SHALL yield ALUResult = 0, and therefore Zero = 1.
REQ-017 On each rising clk with reset low and InValid high: ResultQ <= ALUResult and ZeroQ <= Zero, with 1-cycle latency.
REQ-018 On each rising clk with reset low and InValid low: ResultQ and ZeroQ SHALL hold their values.
REQ-019 ValidQ <= InValid on every rising clk while reset is low.
REQ-020 There SHALL be no backpressure; a new capture every cycle is permitted.

Reset
REQ-021 While reset is high at a rising clk: ResultQ = 0, ZeroQ = 0 and ValidQ = 0; reset SHALL take precedence over InValid.
REQ-022 Reset SHALL NOT affect the combinational ALUResult and Zero outputs.
REQ-023 Reset asserted mid-stream SHALL discard the pending capture, so ValidQ = 0 in the following cycle.

Configuration
REQ-024 Macro ALU_CINATE_FLAGS_EN: when defined, the block SHALL add combinational outputs Carry, Overflow and Negative, each 1 bit wide.
REQ-025 With ALU_CINATE_FLAGS_EN defined, the flags SHALL behave as follows.
- Negative = ALUResult[31].
- Carry = carry-out of A+B for ADD, and NOT borrow (A >= B unsigned) for SUB.
- Overflow = signed overflow for ADD/SUB.
- Carry and Overflow = 0 for all other ops.
REQ-026 Without ALU_CINATE_FLAGS_EN, the ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package alu_cinate_pkg SHALL hold the following:
- the 4-bit ALUControl opcode enum/localparams;
- DATA_W = 32;
- SHAMT_W = 5.
REQ-028 Sub-module alu_cinate_shifter SHALL implement SLL/SRL/SRA, taking the operand, the shift amount and a 2-bit shift type.
REQ-029 The top module SHALL contain the following:
- a shared adder/subtractor, with SUB as A + ~B + 1, that also feeds SLT/SLTU;
- the logic ops;
- the result mux;
- the output register.

Verification
REQ-030 ADD with A=10, B=20 -> 30; ADD with A=0xFFFFFFFF, B=1 -> 0 and Zero=1.
REQ-031 SUB with A=50, B=50 -> 0 and Zero=1; SUB with A=10, B=20 -> 0xFFFFFFF6 and Zero=0.
REQ-032 With A=0xF0F0F0F0, B=0x0F0F0F0F: AND -> 0x00000000, OR -> 0xFFFFFFFF, XOR -> 0xFFFFFFFF.
REQ-033 Shifts: SLL 1 by 4 -> 0x10; SRL 0xF0000000 by 4 -> 0x0F000000; SRA 0xF0000000 by 4 -> 0xFF000000; SrcB=0x24 shifts by 4.
REQ-034 With A=0xFFFFFFFF, B=1: SLT -> 1 and SLTU -> 0; unused code 1111 -> result 0 and Zero=1.
REQ-035 Registered path and randomized check, in this order:
- hold reset 2 cycles -> ResultQ=0, ValidQ=0;
- InValid=1 with ADD 10+20 -> the next cycle shows ResultQ=30, ValidQ=1;
- InValid=0 -> ResultQ holds;
- 1000 random ops match a reference model.
